// File: rtl/ysyx_23060221_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, AXI
// encodings and the default reset PC.
package ysyx_23060221_ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_OUT,
    ST_WAIT
  } ifu_state_e;

  localparam logic [2:0]  SIZE_4B          = 3'b010;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [1:0]  BURST_INCR       = 2'b01;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  // A fetch address is legal only when word aligned.
  function automatic logic pc_aligned(input logic [1:0] pc_lo);
    return (pc_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit: owns the PC, issues one AXI4 read per
// instruction, hands the word to decode over valid/ready, then waits for
// the backend's next-PC redirect before fetching again.
module ysyx_23060221_ifu
  import ysyx_23060221_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter bit          LANE_SEL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        w_fault;      // transition targets OUT with a misaligned-PC fault
  logic        w_redir_take; // redirect accepted this cycle
  logic [31:0] w_lane;

  logic        r_arvalid;
  logic        r_rready;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_err;

  // Upper 32-bit lane when the PC points at the high word of the beat.
  assign w_lane = (LANE_SEL && r_pc[2]) ? rdata[63:32] : rdata[31:0];

  // Redirects count only while waiting, or together with the OUT handshake.
  assign w_redir_take = redirect_valid &&
                        ((r_state == ST_WAIT) ||
                         (r_state == ST_OUT && inst_ready));

  // Next-state and next-PC selection.
  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (pc_aligned(r_pc[1:0])) begin
          w_state_next = ST_AR;
        end else begin
          w_state_next = ST_OUT;
          w_fault      = 1'b1;
        end
      end
      ST_AR:   if (arready) w_state_next = ST_R;
      ST_R:    if (rvalid)  w_state_next = ST_OUT;
      ST_OUT:  if (inst_ready) w_state_next = ST_WAIT;
      ST_WAIT: w_state_next = ST_WAIT;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_redir_take) begin
      w_pc_next = redirect_pc;
      if (pc_aligned(redirect_pc[1:0])) begin
        w_state_next = ST_AR;
      end else begin
        w_state_next = ST_OUT;
        w_fault      = 1'b1;
      end
    end
  end

  // State and PC registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Registered handshake outputs and the instruction payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_err   <= 1'b0;
    end else begin
      r_arvalid    <= (w_state_next == ST_AR);
      r_rready     <= (w_state_next == ST_R);
      r_inst_valid <= (w_state_next == ST_OUT);
      if (w_fault) begin
        r_inst     <= '0;
        r_inst_pc  <= w_pc_next;
        r_inst_err <= 1'b1;
      end else if (r_state == ST_R && rvalid) begin
        r_inst     <= w_lane;
        r_inst_pc  <= r_pc;
        r_inst_err <= (rresp != RESP_OKAY);
      end else if (w_state_next == ST_AR && r_state != ST_AR) begin
        r_inst_err <= 1'b0;
      end
    end
  end

  assign arvalid    = r_arvalid;
  assign araddr     = r_pc;
  assign arsize     = SIZE_4B;
  assign rready     = r_rready;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_err   = r_inst_err;

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Scoreboard bench for the fetch unit: a bus model serves planned reads,
// the stimulus pushes expected instructions, a monitor pops and compares.
module tb_ysyx_23060221_ifu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  ysyx_23060221_ifu dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ar_delay;
    int          r_delay;
    logic [63:0] data;
    logic [1:0]  resp;
  } plan_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: what decode must see for a fetch of pc.
  task automatic schedule(input logic [31:0] pc, input logic [63:0] data,
                          input logic [1:0] resp, input int ard, input int rd);
    plan_t p;
    exp_t  e;
    if (pc % 4 != 0) begin
      e.inst = 32'h0;
      e.pc   = pc;
      e.err  = 1'b1;
    end else begin
      p.addr = pc; p.ar_delay = ard; p.r_delay = rd; p.data = data; p.resp = resp;
      plan_q.push_back(p);
      e.inst = pc[2] ? data[63:32] : data[31:0];
      e.pc   = pc;
      e.err  = (resp != 2'b00);
    end
    exp_q.push_back(e);
  endtask

  // AXI read slave serving the planned transactions in order.
  typedef enum {SL_IDLE, SL_ARW, SL_ARH, SL_RW, SL_RH} sl_e;
  sl_e   sl;
  plan_t cur;
  int    cnt;

  task automatic drive_r();
    rvalid = 1'b1;
    rdata  = cur.data;
    rresp  = cur.resp;
    sl     = SL_RH;
  endtask

  initial begin
    sl = SL_IDLE; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sl = SL_IDLE; arready = 1'b0; rvalid = 1'b0;
      end else begin
        case (sl)
          SL_IDLE: if (arvalid) begin
            if (plan_q.size() == 0) begin
              check("ar_unexpected", 1, 0);
            end else begin
              cur = plan_q.pop_front();
              check("araddr", araddr, cur.addr);
              check("arsize", arsize, 3'b010);
              cnt = cur.ar_delay;
              if (cnt == 0) begin arready = 1'b1; sl = SL_ARH; end
              else sl = SL_ARW;
            end
          end
          SL_ARW: begin
            check("arvalid_hold", arvalid, 1);
            check("araddr_hold", araddr, cur.addr);
            cnt--;
            if (cnt == 0) begin arready = 1'b1; sl = SL_ARH; end
          end
          SL_ARH: begin
            arready = 1'b0;
            check("ar_single_handshake", arvalid, 0);
            check("rready_high", rready, 1);
            cnt = cur.r_delay;
            if (cnt == 0) drive_r();
            else sl = SL_RW;
          end
          SL_RW: begin
            check("rready_high", rready, 1);
            cnt--;
            if (cnt == 0) drive_r();
          end
          default: begin
            rvalid = 1'b0;
            rdata  = {$urandom, $urandom};
            rresp  = 2'($urandom_range(0, 3));
            check("rready_drop", rready, 0);
            sl = SL_IDLE;
          end
        endcase
      end
    end
  end

  // Monitor: payload stability while stalled, protocol, scoreboard pop.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_inst, prev_pc;
  logic        prev_err;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", inst_valid, 1);
          check("hold_inst", inst, prev_inst);
          check("hold_pc", inst_pc, prev_pc);
          check("hold_err", inst_err, prev_err);
        end
        if (redirect_valid) check("redirect_in_ar_or_r", {arvalid, rready}, 2'b00);
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_inst", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("inst", inst, e.inst);
            check("inst_pc", inst_pc, e.pc);
            check("inst_err", inst_err, e.err);
          end
        end
        prev_hold = inst_valid && !inst_ready;
        prev_inst = inst; prev_pc = inst_pc; prev_err = inst_err;
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("inst_valid_timeout", inst_valid, 1);
  endtask

  // Stall `hold` cycles, then handshake; optionally redirect in the same cycle.
  task automatic accept(input int hold, input bit simult, input logic [31:0] npc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    if (simult) begin
      redirect_valid = 1'b1;
      redirect_pc    = npc;
    end
    @(posedge clk); #1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    check("valid_after_handshake", inst_valid, simult && (npc[1:0] != 2'b00));
  endtask

  task automatic redirect(input logic [31:0] npc);
    redirect_valid = 1'b1;
    redirect_pc    = npc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_err", inst_err, 0);
    check("rst_araddr", araddr, RST_PC);
    check("rst_arsize", arsize, 3'b010);

    // First fetch: inst_valid after the third edge following release.
    schedule(RST_PC, 64'h0000_0013_DEAD_BEEF, 2'b00, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ar_entry", arvalid, 1);
    n = 1;
    while (!inst_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("fetch_latency", n, 3);
    accept(5, 1'b0, 32'h0);

    // Upper lane.
    schedule(32'h3000_0004, 64'h0000_0013_DEAD_BEEF, 2'b00, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    redirect(32'h3000_0004);
    wait_valid();

    // Slow arbiter grant.
    schedule(32'h3000_0008, {$urandom, $urandom}, 2'b00, 4, 1);
    accept(0, 1'b0, 32'h0);
    redirect(32'h3000_0008);
    wait_valid();

    // Misaligned redirect: fault without any bus traffic.
    schedule(32'h3000_0002, 64'h0, 2'b00, 0, 0);
    accept(1, 1'b0, 32'h0);
    redirect(32'h3000_0002);
    wait_valid();

    // Slave error response, then a clean fetch via a same-cycle redirect.
    schedule(32'h3000_000C, {$urandom, $urandom}, 2'b10, 1, 0);
    accept(0, 1'b0, 32'h0);
    redirect(32'h3000_000C);
    wait_valid();
    schedule(32'h3000_0010, {$urandom, $urandom}, 2'b00, 0, 2);
    accept(0, 1'b1, 32'h3000_0010);
    wait_valid();

    // Reset while the read data is outstanding.
    schedule(32'h3000_0100, {$urandom, $urandom}, 2'b00, 0, 6);
    accept(0, 1'b0, 32'h0);
    redirect(32'h3000_0100);
    n = 0;
    while (!rready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_r_state", rready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_inst_valid", inst_valid, 0);
    check("midrst_inst_err", inst_err, 0);
    check("midrst_araddr", araddr, RST_PC);
    exp_q.delete();
    plan_q.delete();
    @(posedge clk); #1;
    schedule(RST_PC, {$urandom, $urandom}, 2'b00, 1, 1);
    rst = 1'b0;
    wait_valid();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] npc;
      logic [1:0]  resp;
      bit          simult;
      int          hold;
      npc = RST_PC + 32'($urandom_range(0, 1023) * 4);
      if ($urandom_range(0, 7) == 0) npc = npc + 32'($urandom_range(1, 3));
      resp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      simult = 1'($urandom_range(0, 1));
      hold   = $urandom_range(0, 3);
      schedule(npc, {$urandom, $urandom}, resp, $urandom_range(0, 3), $urandom_range(0, 3));
      if (simult) begin
        accept(hold, 1'b1, npc);
      end else begin
        accept(hold, 1'b0, 32'h0);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          @(posedge clk); #1;
        end
        redirect(npc);
      end
      wait_valid();
    end
    accept(0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    check("plan_drained", plan_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
